// File: rtl/matrix_update_arbiter_if.sv
// Request, clear and board-matrix signals between the board owner and its clients.
// The slave modport is the matrix_update_arbiter side of the link.
interface matrix_update_arbiter_if;
    logic             vblank;
    logic             req0;
    logic [5:0]       idx0;
    logic [3:0]       val0;
    logic             gnt0;
    logic             req1;
    logic [5:0]       idx1;
    logic [3:0]       val1;
    logic             gnt1;
    logic             clr_req;
    logic [3:0]       clr_val;
    logic             clr_done;
    logic             busy;
    logic [63:0][3:0] matrix;

    modport master (
        output vblank, req0, idx0, val0, req1, idx1, val1, clr_req, clr_val,
        input  gnt0, gnt1, clr_done, busy, matrix
    );

    modport slave (
        input  vblank, req0, idx0, val0, req1, idx1, val1, clr_req, clr_val,
        output gnt0, gnt1, clr_done, busy, matrix
    );
endinterface

// File: rtl/matrix_update_arbiter.sv
// Sole writer of the 64-cell board: round-robin single-cell writes plus a bulk clear,
// with every commit confined to the vertical-blanking window.
module matrix_update_arbiter #(
    parameter bit         SYNC_TO_VBLANK = 1'b1,
    parameter logic [3:0] RESET_VAL      = 4'd0
) (
    input logic clk,
    input logic rst,
    matrix_update_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, state_next;
    logic [63:0][3:0] mat_q;
    logic [5:0]       cnt, cnt_next;
    logic             pending, pend_clear;
    logic [3:0]       fill_val;
    logic             gnt0_q, gnt1_q, gnt0_next, gnt1_next;
    logic             done_q, done_next;
    logic             last, last_next;
    logic             wr_en;
    logic [5:0]       wr_idx;
    logic [3:0]       wr_val;
    logic             win, elig0, elig1;

    assign win = SYNC_TO_VBLANK ? bus.vblank : 1'b1;

    // A requester still holding req in its own grant cycle must not be granted again.
    assign elig0 = bus.req0 & ~gnt0_q;
    assign elig1 = bus.req1 & ~gnt1_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pend_clear = 1'b0;
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
        done_next  = 1'b0;
        last_next  = last;
        wr_en      = 1'b0;
        wr_idx     = cnt;
        wr_val     = fill_val;
        case (state)
            IDLE: begin
                if (win) begin
                    if (pending) begin
                        state_next = CLEAR;
                    end else if (elig0 && (!elig1 || last)) begin
                        gnt0_next = 1'b1;
                        wr_en     = 1'b1;
                        wr_idx    = bus.idx0;
                        wr_val    = bus.val0;
                        last_next = 1'b0;
                    end else if (elig1) begin
                        gnt1_next = 1'b1;
                        wr_en     = 1'b1;
                        wr_idx    = bus.idx1;
                        wr_val    = bus.val1;
                        last_next = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (win) begin
                    wr_en    = 1'b1;
                    cnt_next = cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state_next = IDLE;
                        pend_clear = 1'b1;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mat_q    <= {64{RESET_VAL}};
            cnt      <= '0;
            pending  <= 1'b0;
            fill_val <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done_q   <= 1'b0;
            last     <= 1'b1;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            gnt0_q <= gnt0_next;
            gnt1_q <= gnt1_next;
            done_q <= done_next;
            last   <= last_next;
            if (wr_en) mat_q[wr_idx] <= wr_val;
            // Clear requests arriving while one is outstanding keep the first fill code.
            if (pend_clear) begin
                pending <= 1'b0;
            end else if (bus.clr_req && !pending) begin
                pending  <= 1'b1;
                fill_val <= bus.clr_val;
            end
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.clr_done = done_q;
    assign bus.busy     = pending;
    assign bus.matrix   = mat_q;
endmodule

// File: tb/tb_matrix_update_arbiter.sv
// Directed scenarios plus a randomized run checked against a cycle-level behavioural
// model of the board owner (pending clear, fill position, last winner).
module tb_matrix_update_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    matrix_update_arbiter_if bus ();

    matrix_update_arbiter #(
        .SYNC_TO_VBLANK(1'b1),
        .RESET_VAL     (4'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0][3:0] m_mat;
    logic             m_gnt0, m_gnt1, m_done, m_pend, m_fill;
    logic [3:0]       m_val;
    int               m_pos;
    int               m_last;

    task automatic model_step();
        logic [63:0][3:0] mat;
        logic g0, g1, dn, pend, fill, drop, e0, e1;
        logic [3:0] v;
        int pos, last, winner;
        mat = m_mat; pend = m_pend; fill = m_fill; v = m_val; pos = m_pos; last = m_last;
        g0 = 1'b0; g1 = 1'b0; dn = 1'b0; drop = 1'b0;
        if (rst) begin
            mat = '0; pend = 1'b0; fill = 1'b0; pos = 0; last = 1; v = '0;
        end else begin
            if (fill) begin
                if (bus.vblank) begin
                    mat[pos] = v;
                    pos++;
                    if (pos == 64) begin
                        pos = 0; fill = 1'b0; drop = 1'b1; dn = 1'b1;
                    end
                end
            end else if (bus.vblank) begin
                if (m_pend) begin
                    fill = 1'b1;
                end else begin
                    e0 = bus.req0 && !m_gnt0;
                    e1 = bus.req1 && !m_gnt1;
                    winner = -1;
                    if (e0 && e1) winner = (last == 1) ? 0 : 1;
                    else if (e0) winner = 0;
                    else if (e1) winner = 1;
                    if (winner == 0) begin
                        mat[bus.idx0] = bus.val0; g0 = 1'b1; last = 0;
                    end else if (winner == 1) begin
                        mat[bus.idx1] = bus.val1; g1 = 1'b1; last = 1;
                    end
                end
            end
            if (drop) pend = 1'b0;
            else if (bus.clr_req && !m_pend) begin
                pend = 1'b1; v = bus.clr_val;
            end
        end
        m_mat  <= mat;  m_pend <= pend; m_fill <= fill; m_val <= v;
        m_pos  <= pos;  m_last <= last;
        m_gnt0 <= g0;   m_gnt1 <= g1;   m_done <= dn;
    endtask

    always @(posedge clk) model_step();

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.vblank = 1'b0; bus.clr_req = 1'b0; bus.clr_val = '0;
        bus.req0 = 1'b0; bus.idx0 = '0; bus.val0 = '0;
        bus.req1 = 1'b0; bus.idx1 = '0; bus.val1 = '0;
        tick(); tick();
        checks++; if (bus.matrix !== '0) begin errors++; $display("FAIL reset_matrix got %h exp 0", bus.matrix); end
        checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got %b exp 0", bus.gnt0); end
        checks++; if (bus.gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1 got %b exp 0", bus.gnt1); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done got %b exp 0", bus.clr_done); end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        bus.vblank = 1'b1;
        bus.req0 = 1'b1; bus.idx0 = 6'd9; bus.val0 = 4'h3;
        tick();
        checks++; if (bus.matrix[9] !== 4'h3) begin errors++; $display("FAIL single_cell9 got %h exp 3", bus.matrix[9]); end
        checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL single_gnt0 got %b exp 1", bus.gnt0); end
        checks++; if (bus.gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt1 got %b exp 0", bus.gnt1); end
        tick();
        checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL single_no_regrant got %b exp 0", bus.gnt0); end
        checks++; if (bus.matrix[9] !== 4'h3) begin errors++; $display("FAIL single_cell9_hold got %h exp 3", bus.matrix[9]); end
        bus.req0 = 1'b0;
        tick();
    endtask

    task automatic test_window_hold();
        bus.vblank = 1'b0;
        bus.req1 = 1'b1; bus.idx1 = 6'd20; bus.val1 = 4'h5;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++; if (bus.gnt1 !== 1'b0) begin errors++; $display("FAIL hold_gnt1 cyc %0d got %b exp 0", i, bus.gnt1); end
            checks++; if (bus.matrix[20] !== 4'h0) begin errors++; $display("FAIL hold_cell20 cyc %0d got %h exp 0", i, bus.matrix[20]); end
        end
        bus.vblank = 1'b1;
        tick();
        checks++; if (bus.matrix[20] !== 4'h5) begin errors++; $display("FAIL hold_commit_cell20 got %h exp 5", bus.matrix[20]); end
        checks++; if (bus.gnt1 !== 1'b1) begin errors++; $display("FAIL hold_commit_gnt1 got %b exp 1", bus.gnt1); end
        bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        // requester 1 won last, so requester 0 goes first
        bus.req0 = 1'b1; bus.idx0 = 6'd7; bus.val0 = 4'h1;
        bus.req1 = 1'b1; bus.idx1 = 6'd7; bus.val1 = 4'h2;
        tick();
        checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin errors++; $display("FAIL cont1_first got %b%b exp 10", bus.gnt0, bus.gnt1); end
        checks++; if (bus.matrix[7] !== 4'h1) begin errors++; $display("FAIL cont1_cell7_a got %h exp 1", bus.matrix[7]); end
        bus.req0 = 1'b0;
        tick();
        checks++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin errors++; $display("FAIL cont1_second got %b%b exp 01", bus.gnt0, bus.gnt1); end
        checks++; if (bus.matrix[7] !== 4'h2) begin errors++; $display("FAIL cont1_cell7_final got %h exp 2", bus.matrix[7]); end
        bus.req1 = 1'b0;
        tick();
        bus.req0 = 1'b1; bus.idx0 = 6'd3; bus.val0 = 4'h4;
        tick();
        checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL solo_gnt0 got %b exp 1", bus.gnt0); end
        bus.req0 = 1'b0;
        tick();
        bus.req0 = 1'b1; bus.idx0 = 6'd11; bus.val0 = 4'h6;
        bus.req1 = 1'b1; bus.idx1 = 6'd11; bus.val1 = 4'h7;
        tick();
        checks++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin errors++; $display("FAIL cont2_first got %b%b exp 01", bus.gnt0, bus.gnt1); end
        checks++; if (bus.matrix[11] !== 4'h7) begin errors++; $display("FAIL cont2_cell11_a got %h exp 7", bus.matrix[11]); end
        bus.req1 = 1'b0;
        tick();
        checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin errors++; $display("FAIL cont2_second got %b%b exp 10", bus.gnt0, bus.gnt1); end
        checks++; if (bus.matrix[11] !== 4'h6) begin errors++; $display("FAIL cont2_cell11_final got %h exp 6", bus.matrix[11]); end
        bus.req0 = 1'b0;
        tick();
    endtask

    task automatic test_clear_pause();
        logic [63:0][3:0] all_a;
        all_a = {64{4'hA}};
        bus.vblank = 1'b1;
        bus.clr_req = 1'b1; bus.clr_val = 4'hA;
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clr_busy_set got %b exp 1", bus.busy); end
        bus.clr_req = 1'b0;
        bus.req0 = 1'b1; bus.idx0 = 6'd0; bus.val0 = 4'hF;
        tick();
        checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL clr_start_gnt0 got %b exp 0", bus.gnt0); end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++; if (bus.matrix[i] !== 4'hA) begin errors++; $display("FAIL clr_fill cell %0d got %h exp a", i, bus.matrix[i]); end
            checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL clr_fill_gnt0 cell %0d got %b exp 0", i, bus.gnt0); end
        end
        bus.vblank = 1'b0;
        bus.clr_req = 1'b1; bus.clr_val = 4'h5;
        for (int i = 0; i < 100; i++) begin
            tick();
            bus.clr_req = 1'b0;
            checks++; if (bus.gnt0 !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL clr_pause cyc %0d got gnt0=%b busy=%b exp 0 1", i, bus.gnt0, bus.busy); end
        end
        for (int i = 0; i < 64; i++) begin
            if (i < 30) begin
                checks++; if (bus.matrix[i] !== 4'hA) begin errors++; $display("FAIL clr_paused_filled cell %0d got %h exp a", i, bus.matrix[i]); end
            end else begin
                checks++; if (bus.matrix[i] !== m_mat[i]) begin errors++; $display("FAIL clr_paused_held cell %0d got %h exp %h", i, bus.matrix[i], m_mat[i]); end
            end
        end
        bus.vblank = 1'b1;
        for (int i = 30; i < 63; i++) begin
            tick();
            checks++; if (bus.matrix[i] !== 4'hA) begin errors++; $display("FAIL clr_resume cell %0d got %h exp a", i, bus.matrix[i]); end
            checks++; if (bus.clr_done !== 1'b0 || bus.busy !== 1'b1 || bus.gnt0 !== 1'b0) begin
                errors++; $display("FAIL clr_resume_flags cell %0d got done=%b busy=%b gnt0=%b exp 0 1 0", i, bus.clr_done, bus.busy, bus.gnt0);
            end
        end
        tick();
        checks++; if (bus.matrix !== all_a) begin errors++; $display("FAIL clr_full_board got %h exp all a", bus.matrix); end
        checks++; if (bus.clr_done !== 1'b1) begin errors++; $display("FAIL clr_done_pulse got %b exp 1", bus.clr_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy_drop got %b exp 0", bus.busy); end
        checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL clr_last_gnt0 got %b exp 0", bus.gnt0); end
        tick();
        checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL clr_done_single got %b exp 0", bus.clr_done); end
        checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL clr_after_gnt0 got %b exp 1", bus.gnt0); end
        checks++; if (bus.matrix[0] !== 4'hF) begin errors++; $display("FAIL clr_after_cell0 got %h exp f", bus.matrix[0]); end
        bus.req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        bus.vblank = 1'b1;
        bus.clr_req = 1'b1; bus.clr_val = 4'hC;
        tick();
        bus.clr_req = 1'b0;
        tick();
        repeat (40) tick();
        checks++; if (bus.matrix[39] !== 4'hC || bus.busy !== 1'b1) begin
            errors++; $display("FAIL midclr_progress got cell39=%h busy=%b exp c 1", bus.matrix[39], bus.busy);
        end
        rst = 1'b1;
        tick();
        checks++; if (bus.matrix !== '0) begin errors++; $display("FAIL midclr_matrix got %h exp 0", bus.matrix); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midclr_busy got %b exp 0", bus.busy); end
        checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL midclr_done got %b exp 0", bus.clr_done); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.clr_done !== 1'b0 || bus.busy !== 1'b0 || bus.matrix !== '0) begin
                errors++; $display("FAIL midclr_after cyc %0d got done=%b busy=%b matrix=%h exp 0 0 0", i, bus.clr_done, bus.busy, bus.matrix);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            checks++; if (bus.matrix !== m_mat) begin errors++; $display("FAIL rand_matrix cyc %0d got %h exp %h", cyc, bus.matrix, m_mat); end
            checks++; if (bus.gnt0 !== m_gnt0) begin errors++; $display("FAIL rand_gnt0 cyc %0d got %b exp %b", cyc, bus.gnt0, m_gnt0); end
            checks++; if (bus.gnt1 !== m_gnt1) begin errors++; $display("FAIL rand_gnt1 cyc %0d got %b exp %b", cyc, bus.gnt1, m_gnt1); end
            checks++; if (bus.busy !== m_pend) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", cyc, bus.busy, m_pend); end
            checks++; if (bus.clr_done !== m_done) begin errors++; $display("FAIL rand_clr_done cyc %0d got %b exp %b", cyc, bus.clr_done, m_done); end
            if ($urandom_range(9) == 0) bus.vblank = ~bus.vblank;
            bus.clr_req = ($urandom_range(149) == 0);
            bus.clr_val = 4'($urandom);
            if (bus.req0) begin
                if (bus.gnt0 || $urandom_range(63) == 0) bus.req0 = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                bus.req0 = 1'b1; bus.idx0 = 6'($urandom_range(15)); bus.val0 = 4'($urandom);
            end
            if (bus.req1) begin
                if (bus.gnt1 || $urandom_range(63) == 0) bus.req1 = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                bus.req1 = 1'b1; bus.idx1 = 6'($urandom_range(15)); bus.val1 = 4'($urandom);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_write();
        test_window_hold();
        test_contention();
        test_clear_pause();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
